// File: rtl/jtag_shift_master_if.sv
// Command/response handshake bundle between a JTAG shift engine and its host.
// The host side uses the master modport, the engine uses slave.
interface jtag_shift_master_if #(
    parameter int MAXBITS = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [4:0]         cmd_nbits_m1;
    logic [MAXBITS-1:0] cmd_tms;
    logic [MAXBITS-1:0] cmd_tdi;
    logic               cmd_capture;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAXBITS-1:0] rsp_tdo;

    modport master (
        output cmd_valid, cmd_nbits_m1, cmd_tms, cmd_tdi, cmd_capture, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  cmd_valid, cmd_nbits_m1, cmd_tms, cmd_tdi, cmd_capture, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo
    );
endinterface

// File: rtl/jtag_shift_master.sv
// Host-side JTAG initiator: shifts 1..MAXBITS bits of TMS/TDI per command at
// TCK = clk/(2*DIV), captures TDO on each TCK rise and optionally returns it.
module jtag_shift_master #(
    parameter int DIV     = 2,
    parameter int MAXBITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    jtag_shift_master_if.slave  bus,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t             state;
    state_t             state_next;
    logic [7:0]         div_cnt;
    logic [4:0]         idx;
    logic [4:0]         idx_next;
    logic [4:0]         nbits_m1_q;
    logic               capture_q;
    logic [MAXBITS-1:0] tms_q;
    logic [MAXBITS-1:0] tdi_q;
    logic [MAXBITS-1:0] tdo_sr;

    logic accept;
    logic rise;
    logic fall;
    logic advance;
    logic phase_end;
    logic last_bit;

    assign phase_end = (div_cnt == 8'd0);
    assign last_bit  = (idx == nbits_m1_q);
    assign idx_next  = idx + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    rise       = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    fall = 1'b1;
                    if (!last_bit) begin
                        advance    = 1'b1;
                        state_next = LOW;
                    end else begin
                        state_next = capture_q ? RESP : IDLE;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the command words are not reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            tms_q <= bus.cmd_tms;
            tdi_q <= bus.cmd_tdi;
        end
    end

    // Pins are registered; the async reset parks TCK low and TMS high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            div_cnt    <= 8'd0;
            idx        <= 5'd0;
            nbits_m1_q <= 5'd0;
            capture_q  <= 1'b0;
            tdo_sr     <= '0;
            tck        <= 1'b0;
            tms        <= 1'b1;
            tdi        <= 1'b0;
        end else begin
            if (accept || rise || fall)
                div_cnt <= DIV_M1;
            else if (state == LOW || state == HIGH)
                div_cnt <= div_cnt - 8'd1;

            if (accept) begin
                idx        <= 5'd0;
                nbits_m1_q <= bus.cmd_nbits_m1;
                capture_q  <= bus.cmd_capture;
                tdo_sr     <= '0;
                tms        <= bus.cmd_tms[0];
                tdi        <= bus.cmd_tdi[0];
            end

            if (rise) begin
                tck         <= 1'b1;
                tdo_sr[idx] <= tdo;
            end

            if (fall) tck <= 1'b0;

            // TMS/TDI move to the next bit on the same edge that drops TCK.
            if (advance) begin
                idx <= idx_next;
                tms <= tms_q[idx_next];
                tdi <= tdi_q[idx_next];
            end
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_tdo   = tdo_sr;
    assign busy          = (state == LOW) || (state == HIGH);

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: three instances (DIV = 1, 2, 3) share stimulus,
// with a pattern target and a behavioural TAP (IDCODE 0xdeadbeef) on TDO.
module tb_jtag_shift_master;

    localparam int MAXBITS = 32;
    localparam logic [31:0] IDCODE = 32'hdeadbeef;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtag_shift_master_if #(.MAXBITS(MAXBITS)) bus1 ();
    jtag_shift_master_if #(.MAXBITS(MAXBITS)) bus2 ();
    jtag_shift_master_if #(.MAXBITS(MAXBITS)) bus3 ();

    int          sel = 2;
    logic        cmd_valid;
    logic [4:0]  cmd_nbits_m1;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        cmd_capture;
    logic        rsp_ready;
    logic        tdo_pin;

    logic busy1, tck1, tms1, tdi1;
    logic busy2, tck2, tms2, tdi2;
    logic busy3, tck3, tms3, tdi3;

    assign bus1.cmd_valid = cmd_valid && (sel == 1);
    assign bus2.cmd_valid = cmd_valid && (sel == 2);
    assign bus3.cmd_valid = cmd_valid && (sel == 3);
    assign bus1.rsp_ready = rsp_ready && (sel == 1);
    assign bus2.rsp_ready = rsp_ready && (sel == 2);
    assign bus3.rsp_ready = rsp_ready && (sel == 3);
    assign bus1.cmd_nbits_m1 = cmd_nbits_m1;
    assign bus2.cmd_nbits_m1 = cmd_nbits_m1;
    assign bus3.cmd_nbits_m1 = cmd_nbits_m1;
    assign bus1.cmd_tms = cmd_tms;
    assign bus2.cmd_tms = cmd_tms;
    assign bus3.cmd_tms = cmd_tms;
    assign bus1.cmd_tdi = cmd_tdi;
    assign bus2.cmd_tdi = cmd_tdi;
    assign bus3.cmd_tdi = cmd_tdi;
    assign bus1.cmd_capture = cmd_capture;
    assign bus2.cmd_capture = cmd_capture;
    assign bus3.cmd_capture = cmd_capture;

    jtag_shift_master #(.DIV(1), .MAXBITS(MAXBITS)) u_div1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
        .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo_pin));
    jtag_shift_master #(.DIV(2), .MAXBITS(MAXBITS)) u_div2 (
        .clk(clk), .rst(rst), .bus(bus2), .busy(busy2),
        .tck(tck2), .tms(tms2), .tdi(tdi2), .tdo(tdo_pin));
    jtag_shift_master #(.DIV(3), .MAXBITS(MAXBITS)) u_div3 (
        .clk(clk), .rst(rst), .bus(bus3), .busy(busy3),
        .tck(tck3), .tms(tms3), .tdi(tdi3), .tdo(tdo_pin));

    logic        m_cmd_ready, m_rsp_valid, m_busy, m_tck, m_tms, m_tdi;
    logic [31:0] m_rsp_tdo;

    always_comb begin
        m_cmd_ready = bus2.cmd_ready;
        m_rsp_valid = bus2.rsp_valid;
        m_rsp_tdo   = bus2.rsp_tdo;
        m_busy      = busy2;
        m_tck       = tck2;
        m_tms       = tms2;
        m_tdi       = tdi2;
        case (sel)
            1: begin
                m_cmd_ready = bus1.cmd_ready; m_rsp_valid = bus1.rsp_valid;
                m_rsp_tdo = bus1.rsp_tdo; m_busy = busy1;
                m_tck = tck1; m_tms = tms1; m_tdi = tdi1;
            end
            3: begin
                m_cmd_ready = bus3.cmd_ready; m_rsp_valid = bus3.rsp_valid;
                m_rsp_tdo = bus3.rsp_tdo; m_busy = busy3;
                m_tck = tck3; m_tms = tms3; m_tdi = tdi3;
            end
            default: ;
        endcase
    end

    // Target side: a pattern source and an IEEE 1149.1 TAP, both updating TDO on TCK falls.
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
        T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:    return m ? T_TLR    : T_RTI;
            T_RTI:    return m ? T_SEL_DR : T_RTI;
            T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
            T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
            T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
            T_EX1_DR: return m ? T_UPD_DR : T_PA_DR;
            T_PA_DR:  return m ? T_EX2_DR : T_PA_DR;
            T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
            T_UPD_DR: return m ? T_SEL_DR : T_RTI;
            T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
            T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
            T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
            T_EX1_IR: return m ? T_UPD_IR : T_PA_IR;
            T_PA_IR:  return m ? T_EX2_IR : T_PA_IR;
            T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
            default:  return m ? T_SEL_DR : T_RTI;
        endcase
    endfunction

    int          tgt_mode = 0;
    logic [31:0] pat = 32'h0;
    int          rise_cnt = 0;
    logic        pat_tdo = 1'b0;
    logic        tap_tdo = 1'b0;
    tap_t        tap_st = T_TLR;
    logic [3:0]  ir = 4'b0001;
    logic [31:0] dr = 32'h0;
    logic        prev_tck = 1'b0;
    logic        prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            tap_st = T_TLR;
            ir     = 4'b0001;
        end else begin
            if (!prev_busy && m_busy) begin
                rise_cnt = 0;
                pat_tdo  = pat[0];
            end
            if (!prev_tck && m_tck) begin
                rise_cnt++;
                case (tap_st)
                    T_TLR:    ir = 4'b0001;
                    T_CAP_DR: dr = (ir == 4'b0001) ? IDCODE : 32'h0;
                    T_SH_DR:  dr = {m_tdi, dr[31:1]};
                    T_CAP_IR: ir = 4'b0101;
                    T_SH_IR:  ir = {m_tdi, ir[3:1]};
                    default:  ;
                endcase
                tap_st = tap_next(tap_st, m_tms);
            end
            if (prev_tck && !m_tck) begin
                pat_tdo = (rise_cnt < 32) ? pat[rise_cnt] : 1'b0;
                tap_tdo = (tap_st == T_SH_DR) ? dr[0] : (tap_st == T_SH_IR) ? ir[0] : 1'b0;
            end
        end
        prev_tck  = m_tck;
        prev_busy = m_busy;
    end

    assign tdo_pin = (tgt_mode != 0) ? tap_tdo : pat_tdo;

    int   errors = 0;
    int   checks = 0;
    logic hist_tck[$];

    function automatic logic [31:0] mask_of(input logic [4:0] nb);
        logic [63:0] one = 64'h1;
        return 32'((one << (int'(nb) + 1)) - 64'h1);
    endfunction

    // Issue one command and follow it until the engine leaves LOW/HIGH.
    task automatic do_cmd(input logic [4:0] nb, input logic [31:0] t_ms, input logic [31:0] t_di,
                          input logic cap, output int lat, output logic [31:0] got_tms,
                          output logic [31:0] got_tdi, output int viol, output logic rv,
                          output bit to);
        int   k;
        int   r;
        logic ptck, ptms, ptdi;
        to = 0; lat = 0; viol = 0; got_tms = '0; got_tdi = '0; rv = 1'b0; r = 0;
        hist_tck.delete();
        @(negedge clk);
        cmd_nbits_m1 = nb; cmd_tms = t_ms; cmd_tdi = t_di; cmd_capture = cap;
        cmd_valid = 1'b1;
        k = 0;
        while (!m_cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!m_cmd_ready) begin
            cmd_valid = 1'b0;
            to = 1;
            return;
        end
        ptck = m_tck; ptms = m_tms; ptdi = m_tdi;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) cmd_valid = 1'b0;
            hist_tck.push_back(m_tck);
            if ((m_tms !== ptms || m_tdi !== ptdi) && m_tck) viol++;
            if (!ptck && m_tck && r < 32) begin
                got_tms[r] = m_tms;
                got_tdi[r] = m_tdi;
                r++;
            end
            ptck = m_tck; ptms = m_tms; ptdi = m_tdi;
        end while (m_busy && k < 5000);
        if (m_busy) to = 1;
        lat = k - 1;
        rv  = m_rsp_valid;
    endtask

    task automatic get_rsp(output logic [31:0] data, output bit to);
        int k = 0;
        to = 0;
        while (!m_rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!m_rsp_valid) begin
            to = 1;
            data = 'x;
            return;
        end
        data = m_rsp_tdo;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({m_cmd_ready, m_rsp_valid, m_busy, m_tck, m_tms, m_tdi} !== 6'b100010) begin
                errors++;
                $display("FAIL reset_values div%0d: ready/rv/busy/tck/tms/tdi got %b expected 100010", s,
                         {m_cmd_ready, m_rsp_valid, m_busy, m_tck, m_tms, m_tdi});
            end
            checks++;
            if (m_rsp_tdo !== 32'h0) begin
                errors++;
                $display("FAIL reset_rsp_tdo div%0d: got %h expected 00000000", s, m_rsp_tdo);
            end
        end
        sel = 2; tgt_mode = 0; pat = $urandom;
        @(negedge clk);
        cmd_nbits_m1 = 5'd31; cmd_tms = 32'h0; cmd_tdi = $urandom; cmd_capture = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !m_tck; i++) @(negedge clk);
        checks++;
        if (m_tck !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_start: tck got %b expected 1", m_tck);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_tck, m_tms, m_rsp_valid, m_busy} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid_async: tck/tms/rv/busy got %b expected 0100",
                     {m_tck, m_tms, m_rsp_valid, m_busy});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: cmd_ready got %b expected 1", m_cmd_ready);
        end
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_rsp_valid || m_busy) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_discard: activity after reset got 1 expected 0");
        end
    endtask

    task automatic test_idcode();
        int lat, viol; logic [31:0] gm, gd, data; logic rv; bit to, to2;
        sel = 2; tgt_mode = 1;
        do_cmd(5'd5, 32'h0000_001f, 32'h0, 1'b0, lat, gm, gd, viol, rv, to);
        checks++;
        if (to || rv !== 1'b0) begin
            errors++;
            $display("FAIL idcode_reset_seq: timeout=%0d rsp_valid got %b expected 0", to, rv);
        end
        do_cmd(5'd2, 32'h0000_0001, 32'h0, 1'b0, lat, gm, gd, viol, rv, to);
        do_cmd(5'd31, 32'h8000_0000, $urandom, 1'b1, lat, gm, gd, viol, rv, to);
        get_rsp(data, to2);
        checks++;
        if (to || to2 || data !== IDCODE) begin
            errors++;
            $display("FAIL idcode_read: got %h expected %h (timeout=%0d/%0d)", data, IDCODE, to, to2);
        end
        checks++;
        if (lat != 2 * 2 * 32) begin
            errors++;
            $display("FAIL idcode_latency: got %0d expected %0d", lat, 2 * 2 * 32);
        end
        tgt_mode = 0;
    endtask

    task automatic test_timing();
        int lat, viol; logic [31:0] gm, gd; logic rv; bit to;
        logic [17:0] got_v, exp_v;
        sel = 3; tgt_mode = 0; pat = $urandom;
        do_cmd(5'd2, 32'h0, 32'h5, 1'b0, lat, gm, gd, viol, rv, to);
        checks++;
        if (to || lat != 18) begin
            errors++;
            $display("FAIL timing_latency: got %0d expected 18 (timeout=%0d)", lat, to);
        end
        got_v = '0; exp_v = '0;
        for (int j = 0; j < 18; j++) begin
            exp_v[j] = ((j / 3) % 2) == 1;
            got_v[j] = (j < hist_tck.size()) ? hist_tck[j] : 1'bx;
        end
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL timing_tck_shape: got %b expected %b", got_v, exp_v);
        end
        checks++;
        if (gd[2:0] !== 3'b101 || viol != 0) begin
            errors++;
            $display("FAIL timing_tdi_seq: got %b (changes while tck high %0d) expected 101 (0)",
                     gd[2:0], viol);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({m_tdi, m_tms, m_rsp_valid, m_tck} !== 4'b1000) begin
            errors++;
            $display("FAIL timing_hold: tdi/tms/rv/tck got %b expected 1000",
                     {m_tdi, m_tms, m_rsp_valid, m_tck});
        end
    endtask

    task automatic test_partial();
        int lat, viol; logic [31:0] gm, gd, data; logic rv; bit to, to2;
        sel = 2; tgt_mode = 0; pat = 32'h5a5a_5aa5;
        do_cmd(5'd7, $urandom, $urandom, 1'b1, lat, gm, gd, viol, rv, to);
        get_rsp(data, to2);
        checks++;
        if (to || to2 || data !== 32'h0000_00a5) begin
            errors++;
            $display("FAIL partial_capture: got %h expected 000000a5", data);
        end
    endtask

    task automatic test_backpressure();
        int lat, viol; logic [31:0] gm, gd, exp_d; logic rv; bit to;
        logic [4:0] nb;
        sel = 2; tgt_mode = 0; pat = $urandom; nb = 5'($urandom_range(0, 31));
        exp_d = pat & mask_of(nb);
        do_cmd(nb, $urandom, $urandom, 1'b1, lat, gm, gd, viol, rv, to);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_rsp_valid, m_cmd_ready, m_tck} !== 3'b100 || m_rsp_tdo !== exp_d) begin
                errors++;
                $display("FAIL backpressure_hold cyc%0d: rv/ready/tck %b tdo %h expected 100 %h",
                         i, {m_rsp_valid, m_cmd_ready, m_tck}, m_rsp_tdo, exp_d);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({m_rsp_valid, m_cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release: rv/ready got %b expected 01", {m_rsp_valid, m_cmd_ready});
        end
    endtask

    task automatic test_back_to_back();
        int   acc = 0;
        bit   rv_seen = 0;
        logic [6:0] got_b, got_t, exp_b, exp_t;
        localparam int PER = 2 * 1 + 1;
        sel = 1; tgt_mode = 0;
        @(negedge clk);
        cmd_nbits_m1 = 5'd0; cmd_tms = $urandom; cmd_tdi = $urandom; cmd_capture = 1'b0;
        cmd_valid = 1'b1;
        if (m_cmd_ready) acc++;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            got_b[i-1] = m_busy;
            got_t[i-1] = m_tck;
            if (m_rsp_valid) rv_seen = 1;
            if (cmd_valid && m_cmd_ready) acc++;
            else if (acc == 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        for (int t = 0; t < 7; t++) begin
            exp_b[t] = (t / PER < 2) && (t % PER < 2);
            exp_t[t] = exp_b[t] && (t % PER >= 1);
        end
        checks++;
        if (got_b !== exp_b) begin
            errors++;
            $display("FAIL b2b_busy: got %b expected %b", got_b, exp_b);
        end
        checks++;
        if (got_t !== exp_t) begin
            errors++;
            $display("FAIL b2b_tck: got %b expected %b", got_t, exp_t);
        end
        checks++;
        if (acc != 2 || rv_seen) begin
            errors++;
            $display("FAIL b2b_accepts: accepts %0d rsp_seen %0d expected 2 0", acc, rv_seen);
        end
    endtask

    task automatic test_random();
        int lat, viol, div; logic [31:0] gm, gd, data, t_ms, t_di, m; logic rv; bit to, to2;
        logic [4:0] nb;
        tgt_mode = 0;
        for (int n = 0; n < 8; n++) begin
            sel = (n % 2 == 1) ? 3 : 2;
            div = sel;
            nb = 5'($urandom_range(0, 31));
            t_ms = $urandom; t_di = $urandom; pat = $urandom;
            m = mask_of(nb);
            do_cmd(nb, t_ms, t_di, 1'b1, lat, gm, gd, viol, rv, to);
            get_rsp(data, to2);
            checks++;
            if (to || to2 || data !== (pat & m)) begin
                errors++;
                $display("FAIL random%0d_tdo: got %h expected %h", n, data, pat & m);
            end
            checks++;
            if (gm !== (t_ms & m) || gd !== (t_di & m)) begin
                errors++;
                $display("FAIL random%0d_pins: tms %h tdi %h expected %h %h", n, gm, gd, t_ms & m, t_di & m);
            end
            checks++;
            if (lat != 2 * div * (int'(nb) + 1) || viol != 0) begin
                errors++;
                $display("FAIL random%0d_timing: latency %0d viol %0d expected %0d 0",
                         n, lat, viol, 2 * div * (int'(nb) + 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_nbits_m1 = '0; cmd_tms = '0; cmd_tdi = '0; cmd_capture = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_idcode();
        test_timing();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
